// File: rtl/cla_sat_pipe.sv
// Pipelined two-level carry-lookahead adder/subtractor with signed
// overflow/underflow detection, optional saturation, a valid/ready
// stream handshake and a sticky overflow event counter.
module cla_sat_pipe #(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             uvf,
    output logic             sat_hit,
    input  logic             clr_count,
    output logic [15:0]      evt_count
);
    localparam int NG  = WIDTH / 4;
    localparam int MSB = WIDTH - 1;

    logic adv, accept, xfer;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~rst;
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;

    logic [WIDTH-1:0] f_be, f_p, f_g;
    logic [NG-1:0]    f_gp, f_gg, f_gc;
    assign f_be = sub ? ~b : b;
    assign f_p  = a ^ f_be;
    assign f_g  = a & f_be;

    // Group propagate/generate for each 4-bit slice
    always_comb begin
        f_gp = '0;
        f_gg = '0;
        for (int k = 0; k < NG; k++) begin
            f_gp[k] = &f_p[4*k +: 4];
            f_gg[k] = f_g[4*k+3]
                    | (f_p[4*k+3] & f_g[4*k+2])
                    | (&f_p[4*k+2 +: 2] & f_g[4*k+1])
                    | (&f_p[4*k+1 +: 3] & f_g[4*k]);
        end
    end

    // Second-level lookahead: every group carry-in is a flat sum of products
    always_comb begin
        logic c, t;
        f_gc = '0;
        c    = 1'b0;
        t    = 1'b0;
        for (int k = 0; k < NG; k++) begin
            c = sub;
            for (int m = 0; m < k; m++) c = c & f_gp[m];
            for (int j = 0; j < k; j++) begin
                t = f_gg[j];
                for (int m = j + 1; m < k; m++) t = t & f_gp[m];
                c = c | t;
            end
            f_gc[k] = c;
        end
    end

    logic             s1_v, s1_sat;
    logic [WIDTH-1:0] s1_a, s1_be;
    logic [NG-1:0]    s1_gp, s1_gg, s1_gc;

    generate
        if (PIPE_STAGES == 2) begin : g_s1_reg
            // Stage 1: capture operands and lookahead terms of accepted beats
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_v   <= 1'b0;
                    s1_sat <= 1'b0;
                    s1_a   <= '0;
                    s1_be  <= '0;
                    s1_gp  <= '0;
                    s1_gg  <= '0;
                    s1_gc  <= '0;
                end else if (adv) begin
                    s1_v <= accept;
                    if (accept) begin
                        s1_sat <= sat;
                        s1_a   <= a;
                        s1_be  <= f_be;
                        s1_gp  <= f_gp;
                        s1_gg  <= f_gg;
                        s1_gc  <= f_gc;
                    end
                end
            end
        end else begin : g_s1_comb
            assign s1_v   = accept;
            assign s1_sat = sat;
            assign s1_a   = a;
            assign s1_be  = f_be;
            assign s1_gp  = f_gp;
            assign s1_gg  = f_gg;
            assign s1_gc  = f_gc;
        end
    endgenerate

    logic [WIDTH-1:0] b_p, b_g, b_raw, b_sum;
    logic             b_cout, b_ovf, b_uvf, b_sat_hit;
    assign b_p = s1_a ^ s1_be;
    assign b_g = s1_a & s1_be;

    // In-group lookahead from each group carry-in, plus carry out of the last group
    always_comb begin
        logic c, t;
        b_raw  = '0;
        b_cout = 1'b0;
        c      = 1'b0;
        t      = 1'b0;
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < 4; i++) begin
                c = s1_gc[k];
                for (int m = 0; m < i; m++) c = c & b_p[4*k+m];
                for (int j = 0; j < i; j++) begin
                    t = b_g[4*k+j];
                    for (int m = j + 1; m < i; m++) t = t & b_p[4*k+m];
                    c = c | t;
                end
                b_raw[4*k+i] = b_p[4*k+i] ^ c;
            end
        end
        c = s1_gc[0];
        for (int m = 0; m < NG; m++) c = c & s1_gp[m];
        for (int j = 0; j < NG; j++) begin
            t = s1_gg[j];
            for (int m = j + 1; m < NG; m++) t = t & s1_gp[m];
            c = c | t;
        end
        b_cout = c;
    end

    assign b_ovf     = ~s1_a[MSB] & ~s1_be[MSB] & b_raw[MSB];
    assign b_uvf     = s1_a[MSB] & s1_be[MSB] & ~b_raw[MSB];
    assign b_sat_hit = s1_sat & (b_ovf | b_uvf);

    // Clamp to the signed extreme on overflow when saturation is requested
    always_comb begin
        b_sum = b_raw;
        if (s1_sat & b_ovf)      b_sum = {1'b0, {(WIDTH-1){1'b1}}};
        else if (s1_sat & b_uvf) b_sum = {1'b1, {(WIDTH-1){1'b0}}};
    end

    // Output register: takes the next beat on advance, holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            uvf       <= 1'b0;
            sat_hit   <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_v;
            if (s1_v) begin
                sum     <= b_sum;
                cout    <= b_cout;
                ovf     <= b_ovf;
                uvf     <= b_uvf;
                sat_hit <= b_sat_hit;
            end
        end
    end

    // Event counter: clear beats increment, holds at full scale
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_count <= '0;
        end else if (clr_count) begin
            evt_count <= '0;
        end else if (xfer && (ovf || uvf) && (evt_count != 16'hFFFF)) begin
            evt_count <= evt_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_cla_sat_pipe.sv
// Bench for cla_sat_pipe: six instances (widths 8/16/32, one and two stages)
// checked every cycle against an arithmetic reference with a slot-per-stage
// occupancy model; directed cases pin the model to hand-computed values.
module tb_cla_sat_pipe;
    localparam int NI = 6;

    function automatic int wfun(int i);
        return (i < 2) ? 8 : (i < 4) ? 16 : 32;
    endfunction

    function automatic int pfun(int i);
        return (i % 2 == 0) ? 2 : 1;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]       rst_v, in_valid_v, sub_v, sat_v, out_ready_v, clr_v;
    logic [NI-1:0][31:0] a_v, b_v;
    logic [NI-1:0]       in_ready_v, out_valid_v, cout_v, ovf_v, uvf_v, sat_hit_v;
    logic [NI-1:0][31:0] sum_v;
    logic [NI-1:0][15:0] evt_v;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int W = wfun(gi);
            localparam int P = pfun(gi);
            logic [W-1:0] sum_w;
            cla_sat_pipe #(.WIDTH(W), .PIPE_STAGES(P)) u_dut (
                .clk       (clk),
                .rst       (rst_v[gi]),
                .in_valid  (in_valid_v[gi]),
                .in_ready  (in_ready_v[gi]),
                .a         (a_v[gi][W-1:0]),
                .b         (b_v[gi][W-1:0]),
                .sub       (sub_v[gi]),
                .sat       (sat_v[gi]),
                .out_valid (out_valid_v[gi]),
                .out_ready (out_ready_v[gi]),
                .sum       (sum_w),
                .cout      (cout_v[gi]),
                .ovf       (ovf_v[gi]),
                .uvf       (uvf_v[gi]),
                .sat_hit   (sat_hit_v[gi]),
                .clr_count (clr_v[gi]),
                .evt_count (evt_v[gi])
            );
            assign sum_v[gi] = 32'(sum_w);
        end
    endgenerate

    int   n_assert = 0;
    int   n_fail   = 0;
    logic chk_en   = 1'b0;

    logic [1:0]  mv   [NI];
    logic [35:0] mdat [NI][2];
    logic [15:0] mcnt [NI];
    int          acc_cnt [NI];
    logic [7:0]  xfer_q [$];

    function automatic void chk(string nm, int i, logic [35:0] got, logic [35:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s idx%0d: got %h expected %h", nm, i, got, exp);
        end
    endfunction

    // {sat_hit, uvf, ovf, cout, sum[31:0]} from signed/unsigned integer arithmetic
    function automatic logic [35:0] ref_calc(int w, logic [31:0] a, logic [31:0] b,
                                             logic sub, logic sat);
        longint m, ua, ub, sa, sb, r, mx, mn, s;
        logic   ov, uv, co;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        mx = m >> 1;
        mn = -(mx + 1);
        sa = (ua > mx) ? ua - (m + 1) : ua;
        sb = (ub > mx) ? ub - (m + 1) : ub;
        r  = sub ? sa - sb : sa + sb;
        ov = (r > mx);
        uv = (r < mn);
        co = sub ? (ua >= ub) : ((ua + ub) > m);
        s  = r & m;
        if (sat && ov)      s = mx;
        else if (sat && uv) s = mn & m;
        return {sat & (ov | uv), uv, ov, co, s[31:0]};
    endfunction

    function automatic logic [31:0] rnd_op(int w);
        logic [31:0] m, r;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        case ($urandom_range(0, 7))
            0:       r = m >> 1;
            1:       r = (m >> 1) + 32'h1;
            2:       r = 32'h0;
            3:       r = m;
            4:       r = 32'h1;
            default: r = $urandom;
        endcase
        return r & m;
    endfunction

    // Compare DUT to model state, then advance the model with the inputs of the coming edge
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int   p;
            logic ov;
            p  = pfun(i);
            ov = mv[i][p-1];
            if (chk_en) begin
                chk("out_valid", i, 36'(out_valid_v[i]), 36'(ov));
                chk("in_ready", i, 36'(in_ready_v[i]), 36'((!ov || out_ready_v[i]) && !rst_v[i]));
                chk("evt_count", i, 36'(evt_v[i]), 36'(mcnt[i]));
                if (ov)
                    chk("result", i, {sat_hit_v[i], uvf_v[i], ovf_v[i], cout_v[i], sum_v[i]},
                        mdat[i][p-1]);
            end
            if (i == 0 && out_valid_v[0] && out_ready_v[0] && !rst_v[0])
                xfer_q.push_back(sum_v[0][7:0]);
            if (rst_v[i]) begin
                mv[i]   = 2'b00;
                mcnt[i] = 16'h0;
            end else begin
                if (clr_v[i])
                    mcnt[i] = 16'h0;
                else if (ov && out_ready_v[i] && (mdat[i][p-1][33] || mdat[i][p-1][34])
                         && mcnt[i] != 16'hFFFF)
                    mcnt[i] = mcnt[i] + 16'd1;
                if (!ov || out_ready_v[i]) begin
                    if (p == 2) begin
                        mv[i][1]   = mv[i][0];
                        mdat[i][1] = mdat[i][0];
                    end
                    mv[i][0]   = in_valid_v[i];
                    mdat[i][0] = ref_calc(wfun(i), a_v[i], b_v[i], sub_v[i], sat_v[i]);
                    if (in_valid_v[i]) acc_cnt[i]++;
                end
            end
        end
    end

    task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic s,
                            input logic st, input logic [3:0] ef, input logic [7:0] es);
        logic got_v;
        got_v = 1'b0;
        @(posedge clk); #1;
        in_valid_v[0]  = 1'b1;
        a_v[0]         = 32'(a);
        b_v[0]         = 32'(b);
        sub_v[0]       = s;
        sat_v[0]       = st;
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        for (int k = 0; k < 8 && !got_v; k++) begin
            @(negedge clk);
            if (out_valid_v[0]) begin
                got_v = 1'b1;
                chk("directed", 0, {sat_hit_v[0], uvf_v[0], ovf_v[0], cout_v[0], sum_v[0]},
                    {ef, 24'h0, es});
            end
        end
        chk("directed_timeout", 0, 36'(got_v), 36'h1);
    endtask

    initial begin
        int   seen;
        logic acc, all_done, got_v;
        int   idx;
        rst_v       = '1;
        in_valid_v  = '0;
        sub_v       = '0;
        sat_v       = '0;
        out_ready_v = '1;
        clr_v       = '0;
        a_v         = '0;
        b_v         = '0;
        for (int i = 0; i < NI; i++) acc_cnt[i] = 0;

        chk("model_ovf_sat", 0, ref_calc(8, 32'h7F, 32'h01, 1'b0, 1'b1), {4'b1010, 32'h7F});
        chk("model_uvf_raw", 0, ref_calc(8, 32'h80, 32'h01, 1'b1, 1'b0), {4'b0101, 32'h7F});
        chk("model_w16_uvf", 0, ref_calc(16, 32'h8000, 32'hFFFF, 1'b0, 1'b1), {4'b1101, 32'h8000});
        chk("model_w32_ovf", 0, ref_calc(32, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1),
            {4'b1010, 32'h7FFF_FFFF});

        repeat (2) @(posedge clk);
        #1;
        rst_v  = '0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_fields", 0, {sat_hit_v[0], uvf_v[0], ovf_v[0], cout_v[0], sum_v[0]}, 36'h0);
        chk("rst_evt", 0, 36'(evt_v[0]), 36'h0);
        chk("rst_ready", 0, 36'(in_ready_v[0]), 36'h1);

        send_one(8'h7F, 8'h01, 1'b0, 1'b1, 4'b1010, 8'h7F);
        send_one(8'h7F, 8'h01, 1'b0, 1'b0, 4'b0010, 8'h80);
        send_one(8'h80, 8'h01, 1'b1, 1'b1, 4'b1101, 8'h80);
        send_one(8'h80, 8'h01, 1'b1, 1'b0, 4'b0101, 8'h7F);
        send_one(8'hFF, 8'h01, 1'b0, 1'b1, 4'b0001, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("evt_after_directed", 0, 36'(evt_v[0]), 36'h4);

        // back-to-back beats with a three-cycle downstream stall
        xfer_q.delete();
        idx = 0;
        for (int c = 0; c < 40 && xfer_q.size() < 6; c++) begin
            @(posedge clk); #1;
            in_valid_v[0]  = (idx < 6);
            a_v[0]         = 32'(idx + 1);
            b_v[0]         = 32'h1;
            sub_v[0]       = 1'b0;
            sat_v[0]       = 1'b0;
            out_ready_v[0] = !(c >= 3 && c < 6);
            @(negedge clk);
            acc = in_valid_v[0] & in_ready_v[0];
            if (c >= 3 && c < 6) chk("stall_in_ready", c, 36'(in_ready_v[0]), 36'h0);
            if (acc) idx++;
        end
        @(posedge clk); #1;
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b1;
        repeat (3) @(posedge clk);
        chk("bp_count", 0, 36'(xfer_q.size()), 36'd6);
        for (int k = 0; k < xfer_q.size() && k < 6; k++)
            chk("bp_order", k, 36'(xfer_q[k]), 36'(k + 2));

        // reset with two beats in flight and evt_count = 5
        send_one(8'h7F, 8'h01, 1'b0, 1'b1, 4'b1010, 8'h7F);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("evt_before_rst", 0, 36'(evt_v[0]), 36'h5);
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;
        in_valid_v[0]  = 1'b1;
        a_v[0]         = 32'h7F;
        b_v[0]         = 32'h01;
        sub_v[0]       = 1'b0;
        sat_v[0]       = 1'b0;
        @(posedge clk); #1;
        a_v[0] = 32'h70;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        rst_v[0]      = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 0, 36'(in_ready_v[0]), 36'h0);
        chk("rst_had_valid", 0, 36'(out_valid_v[0]), 36'h1);
        @(posedge clk); #1;
        rst_v[0]       = 1'b0;
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 0, 36'(out_valid_v[0]), 36'h0);
        chk("post_rst_evt", 0, 36'(evt_v[0]), 36'h0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid_v[0]) seen++;
        end
        chk("stale_beats", 0, 36'(seen), 36'h0);

        // clear in the same cycle as an overflowing transfer
        send_one(8'h7F, 8'h01, 1'b0, 1'b0, 4'b0010, 8'h80);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("evt_before_clr", 0, 36'(evt_v[0]), 36'h1);
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;
        in_valid_v[0]  = 1'b1;
        a_v[0]         = 32'h7F;
        b_v[0]         = 32'h01;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        got_v = 1'b0;
        for (int k = 0; k < 6 && !got_v; k++) begin
            @(negedge clk);
            got_v = out_valid_v[0];
        end
        chk("clr_setup_valid", 0, 36'(got_v), 36'h1);
        @(posedge clk); #1;
        out_ready_v[0] = 1'b1;
        clr_v[0]       = 1'b1;
        @(posedge clk); #1;
        clr_v[0] = 1'b0;
        @(negedge clk);
        chk("clr_wins", 0, 36'(evt_v[0]), 36'h0);

        // randomized traffic on every instance
        for (int i = 0; i < NI; i++) acc_cnt[i] = 0;
        all_done = 1'b0;
        for (int c = 0; c < 40000 && !all_done; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                in_valid_v[i]  = (acc_cnt[i] < 10000) && ($urandom_range(0, 3) != 0);
                a_v[i]         = rnd_op(wfun(i));
                b_v[i]         = rnd_op(wfun(i));
                sub_v[i]       = 1'($urandom_range(0, 1));
                sat_v[i]       = 1'($urandom_range(0, 1));
                out_ready_v[i] = ($urandom_range(0, 3) != 0);
                clr_v[i]       = ($urandom_range(0, 63) == 0);
                rst_v[i]       = ($urandom_range(0, 2999) == 0);
            end
            all_done = 1'b1;
            for (int i = 0; i < NI; i++)
                if (acc_cnt[i] < 10000) all_done = 1'b0;
        end
        @(posedge clk); #1;
        in_valid_v  = '0;
        out_ready_v = '1;
        rst_v       = '0;
        clr_v       = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk("random_beats_done", i, 36'(acc_cnt[i] >= 10000), 36'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "simulation time limit reached");
    end

endmodule
